motion_diff_detector: RTL

Frame-difference motion front end for the 320x240 tracking path. It converts each incoming RGB565 camera pixel to 8-bit gray and reads the co-located pixel of the previous frame from an external synchronous frame buffer. It flags pixels whose gray difference exceeds a threshold, then overwrites the buffer with the current value. Its outputs (`diff_detected`, `x_pixel`, `y_pixel`, `frame_done`) are the per-pixel motion stream consumed by the centroid/box tracker.

---
 rtl/motion_diff_detector.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/motion_diff_detector.sv
`default_nettype none
// ============================================================================
// Module   : motion_diff_detector
// Brief    : RGB565 -> gray frame-difference motion detector. Reads the
//            co-located previous-frame gray from a synchronous frame buffer,
//            flags pixels whose difference exceeds a threshold, writes back.
// Revision : 1.0 - initial release
// ============================================================================
module motion_diff_detector #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pixel_valid,
    input  logic [15:0]       pixel_data,
    input  logic [7:0]        diff_threshold,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [7:0]        mem_wr_data,
    output logic              diff_detected,
    output logic [9:0]        x_pixel,
    output logic [9:0]        y_pixel,
    output logic              frame_done,
    output logic [ADDR_W-1:0] diff_count,
    output logic              frame_valid
);

    localparam logic [9:0]        C_X_LAST  = 10'(H_RES - 1);
    localparam logic [9:0]        C_Y_LAST  = 10'(V_RES - 1);
    localparam logic [ADDR_W-1:0] C_CNT_MAX = '1;

    // Input position tracking
    logic [9:0]        x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic              done_q, done_d, gen_q, gen_d;
    logic [9:0]        cur_x, cur_y;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_done, cur_last, accept;
    logic [9:0]        gray_sum;
    logic [7:0]        gray;

    // Stage 1: read address issued, pixel attributes carried along
    logic              s1_valid_q, s1_last_q, s1_gen_q;
    logic [7:0]        s1_gray_q, s1_thr_q;
    logic [9:0]        s1_x_q, s1_y_q;
    logic [ADDR_W-1:0] s1_addr_q;

    // Stage 2: read data arrives, compare and write back
    logic              s2_valid_q, s2_last_q, s2_gen_q;
    logic [7:0]        s2_gray_q, s2_thr_q;
    logic [9:0]        s2_x_q, s2_y_q;
    logic [ADDR_W-1:0] s2_addr_q;
    logic [7:0]        abs_diff;
    logic              flag;

    // Stage 3: registered motion output
    logic              s3_valid_q, s3_last_q, s3_gen_q;
    logic              det_q;
    logic [9:0]        x_pix_q, y_pix_q;

    // Frame bookkeeping
    logic [ADDR_W-1:0] cnt_q, cnt_inc, diff_count_q;
    logic              frame_done_q, frame_valid_q;
    logic              frame_end, count_hit;

    // Next position: frame_start clears first so a coincident pixel lands at (0,0).
    // An abort (frame_start before the last pixel) flips the generation tag so
    // in-flight pixels of the dropped frame are kept out of the new flag total.
    always_comb begin
        cur_x      = frame_start ? 10'd0 : x_cnt_q;
        cur_y      = frame_start ? 10'd0 : y_cnt_q;
        cur_addr   = frame_start ? '0 : addr_cnt_q;
        cur_done   = frame_start ? 1'b0 : done_q;
        cur_last   = (cur_x == C_X_LAST) && (cur_y == C_Y_LAST);
        accept     = pixel_valid && !cur_done;
        gen_d      = (frame_start && !done_q) ? ~gen_q : gen_q;
        x_cnt_d    = cur_x;
        y_cnt_d    = cur_y;
        addr_cnt_d = cur_addr;
        done_d     = cur_done;
        if (accept) begin
            addr_cnt_d = cur_addr + ADDR_W'(1);
            if (cur_last) begin
                done_d = 1'b1;
            end
            if (cur_x == C_X_LAST) begin
                x_cnt_d = 10'd0;
                y_cnt_d = cur_y + 10'd1;
            end else begin
                x_cnt_d = cur_x + 10'd1;
            end
        end
        gray_sum = {2'b00, pixel_data[15:11], 3'b000}
                 + {1'b0,  pixel_data[10:5],  3'b000}
                 + {2'b00, pixel_data[4:0],   3'b000};
        gray     = 8'(gray_sum >> 2);
    end

    // Compare against the previous frame; warm-up suppresses every flag
    always_comb begin
        abs_diff = (s2_gray_q >= mem_rd_data) ? (s2_gray_q - mem_rd_data)
                                              : (mem_rd_data - s2_gray_q);
        flag      = s2_valid_q && frame_valid_q && (abs_diff > s2_thr_q);
        frame_end = s3_valid_q && s3_last_q;
        count_hit = s3_valid_q && det_q && (s3_gen_q == gen_q);
        cnt_inc   = (count_hit && (cnt_q != C_CNT_MAX)) ? cnt_q + ADDR_W'(1) : cnt_q;
    end

    // Position counters and generation tag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_cnt_q    <= '0;
            y_cnt_q    <= '0;
            addr_cnt_q <= '0;
            done_q     <= 1'b0;
            gen_q      <= 1'b0;
        end else begin
            x_cnt_q    <= x_cnt_d;
            y_cnt_q    <= y_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            done_q     <= done_d;
            gen_q      <= gen_d;
        end
    end

    // Three-stage pixel pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0; s1_last_q <= 1'b0; s1_gen_q <= 1'b0;
            s1_gray_q  <= '0;   s1_thr_q  <= '0;
            s1_x_q     <= '0;   s1_y_q    <= '0;   s1_addr_q <= '0;
            s2_valid_q <= 1'b0; s2_last_q <= 1'b0; s2_gen_q <= 1'b0;
            s2_gray_q  <= '0;   s2_thr_q  <= '0;
            s2_x_q     <= '0;   s2_y_q    <= '0;   s2_addr_q <= '0;
            s3_valid_q <= 1'b0; s3_last_q <= 1'b0; s3_gen_q <= 1'b0;
            det_q      <= 1'b0; x_pix_q   <= '0;   y_pix_q   <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_last_q <= cur_last;
                s1_gen_q  <= gen_d;
                s1_gray_q <= gray;
                s1_thr_q  <= diff_threshold;
                s1_x_q    <= cur_x;
                s1_y_q    <= cur_y;
                s1_addr_q <= cur_addr;
            end
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s2_gen_q   <= s1_gen_q;
            s2_gray_q  <= s1_gray_q;
            s2_thr_q   <= s1_thr_q;
            s2_x_q     <= s1_x_q;
            s2_y_q     <= s1_y_q;
            s2_addr_q  <= s1_addr_q;
            s3_valid_q <= s2_valid_q;
            s3_last_q  <= s2_last_q;
            s3_gen_q   <= s2_gen_q;
            det_q      <= flag;
            if (s2_valid_q) begin
                x_pix_q <= s2_x_q;
                y_pix_q <= s2_y_q;
            end
        end
    end

    // Flag accumulation, frame completion pulse and warm-up status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            diff_count_q  <= '0;
            frame_done_q  <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
            if (frame_end) begin
                diff_count_q  <= frame_valid_q ? cnt_inc : '0;
                cnt_q         <= '0;
                frame_valid_q <= 1'b1;
            end else if (frame_start && !done_q) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_inc;
            end
        end
    end

    assign mem_rd_addr   = s1_addr_q;
    assign mem_wr_en     = s2_valid_q;
    assign mem_wr_addr   = s2_addr_q;
    assign mem_wr_data   = s2_gray_q;
    assign diff_detected = det_q;
    assign x_pixel       = x_pix_q;
    assign y_pixel       = y_pix_q;
    assign frame_done    = frame_done_q;
    assign diff_count    = diff_count_q;
    assign frame_valid   = frame_valid_q;

endmodule
`default_nettype wire
